// File: rtl/laser500_uart_tx.sv
// Purpose : 8N1 serial transmitter for the Laser 500 core, fed from a byte FIFO, drives UART_TXD.
// Latency : byte accepted into an empty FIFO while idle (cts_n low) -> UART_TXD falls 2 edges later.
// Backpr. : tx_ready drops while the FIFO holds FIFO_DEPTH bytes; cts_n high holds frames at frame start.
//
// Ports:
//   F14M        system clock, all logic on its rising edge
//   reset_n     asynchronous active-low reset (flushes FIFO, aborts frame, line high)
//   tx_data     byte to send, written when tx_valid && tx_ready
//   tx_valid    tx_data is valid this cycle
//   tx_ready    FIFO can accept a byte this cycle (registered)
//   cts_n       clear-to-send, active low, 2-flop synchronised, sampled only at frame start
//   UART_TXD    serial line, idles high (registered)
//   busy        a frame is on the line or the FIFO is non-empty (registered, aligned with UART_TXD)
//   fifo_count  bytes currently held in the FIFO
//
// Optional build macro: LASER500_UART_TX_PARITY_EN inserts an even-parity bit (8E1 framing).

module laser500_uart_tx #(
    parameter int CLK_HZ     = 14700000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          F14M,
    input  logic                          reset_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          cts_n,
    output logic                          UART_TXD,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int NW  = AW + 1;

    localparam logic [CW-1:0] CNT_RELOAD = CW'(DIV - 1);

`ifdef LASER500_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           txd_q, txd_d;
    logic           busy_q, busy_d;
`ifdef LASER500_UART_TX_PARITY_EN
    logic           par_q, par_d;
`endif

    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]  count_q, count_d;
    logic           ready_q, ready_d;

    logic           cts_s1_q, cts_s2_q;

    logic           push, pop, can_start, bit_end;
    logic [7:0]     head;

    // ------------------------------------------------------------------
    // cts_n synchroniser; resets to "not clear" so nothing starts early
    // ------------------------------------------------------------------
    always_ff @(posedge F14M or negedge reset_n) begin
        if (!reset_n) begin
            cts_s1_q <= 1'b1;
            cts_s2_q <= 1'b1;
        end else begin
            cts_s1_q <= cts_n;
            cts_s2_q <= cts_s1_q;
        end
    end

    // ------------------------------------------------------------------
    // FIFO control. A write is gated by the registered ready, so a full
    // FIFO refuses the byte even when the FSM pops on the same edge.
    // ------------------------------------------------------------------
    assign push      = tx_valid && ready_q;
    assign head      = mem_q[rd_ptr_q];
    assign can_start = (count_q != '0) && !cts_s2_q;
    assign bit_end   = (cnt_q == '0);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d < NW'(FIFO_DEPTH));
    end

    always_ff @(posedge F14M) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    always_ff @(posedge F14M or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM. The bit counter reloads to DIV-1 on entry to every bit
    // and the bit ends on the cycle it reads zero, giving DIV cycles.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? cnt_q : cnt_q - CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef LASER500_UART_TX_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (can_start) begin
                    pop     = 1'b1;
                    shift_d = head;
`ifdef LASER500_UART_TX_PARITY_EN
                    par_d   = ^head;
`endif
                    cnt_d   = CNT_RELOAD;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = 3'd0;
                    cnt_d   = CNT_RELOAD;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = CNT_RELOAD;
                    if (idx_q == 3'd7) begin
`ifdef LASER500_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef LASER500_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = CNT_RELOAD;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Chain straight into the next start bit when allowed, no idle gap.
                if (bit_end) begin
                    if (can_start) begin
                        pop     = 1'b1;
                        shift_d = head;
`ifdef LASER500_UART_TX_PARITY_EN
                        par_d   = ^head;
`endif
                        cnt_d   = CNT_RELOAD;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line and busy are registered from the current state so both move
    // together one edge behind the FSM.
    always_comb begin
        case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
`ifdef LASER500_UART_TX_PARITY_EN
            PARITY:  txd_d = par_q;
`endif
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_q != IDLE) || (count_q != '0);
    end

    always_ff @(posedge F14M or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
`ifdef LASER500_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
`ifdef LASER500_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx_ready   = ready_q;
    assign UART_TXD   = txd_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

endmodule
